// File: rtl/roberts_mdc_engine.sv
// Job-sequencing shell around a Roberts-cross kernel: size load, pixel passthrough, 2-deep result FIFO.
// Optional busy-cycle counter when ROBERTS_MDC_ENGINE_PERF_EN is defined.
module roberts_mdc_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  cnt_limit_i,
  input  logic                  in_size_valid_i,
  input  logic [DATA_WIDTH-1:0] in_size_data_i,
  output logic                  in_size_ready_o,
  input  logic                  in_pel_valid_i,
  input  logic [DATA_WIDTH-1:0] in_pel_data_i,
  output logic                  in_pel_ready_o,
  output logic [DATA_WIDTH-1:0] k_size_o,
  output logic                  k_in_pel_valid_o,
  output logic [DATA_WIDTH-1:0] k_in_pel_data_o,
  input  logic                  k_in_pel_ready_i,
  input  logic                  k_out_pel_valid_i,
  input  logic [DATA_WIDTH-1:0] k_out_pel_data_i,
  output logic                  k_out_pel_ready_o,
  output logic                  out_pel_valid_o,
  output logic [DATA_WIDTH-1:0] out_pel_data_o,
  input  logic                  out_pel_ready_i,
  output logic [CNT_WIDTH-1:0]  cnt_out_pel_o,
  output logic                  done_o,
  output logic                  ready_o
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
  ,
  output logic [31:0]           busy_cycles_o
`endif
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned OCC_WIDTH  = 2;

  typedef enum logic [1:0] {IDLE, LOAD_SIZE, RUN, FLUSH} state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [OCC_WIDTH-1:0]   occ;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   limit;
  logic [CNT_WIDTH-1:0]   count_nxt;
  logic [DATA_WIDTH-1:0]  k_size;
  logic                   done;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   in_run;
  logic                   push;
  logic                   pop;

  // Streaming paths are combinational; everything is forced quiet while in reset.
  assign fifo_full         = (occ == OCC_WIDTH'(FIFO_DEPTH));
  assign fifo_empty        = (occ == '0);
  assign in_run            = rst_ni && (state == RUN);
  assign k_in_pel_valid_o  = in_run && in_pel_valid_i && enable_i;
  assign in_pel_ready_o    = in_run && k_in_pel_ready_i && enable_i;
  assign k_in_pel_data_o   = in_pel_data_i;
  assign in_size_ready_o   = rst_ni && (state == LOAD_SIZE) && enable_i;
  assign k_out_pel_ready_o = in_run && enable_i && !fifo_full;
  assign out_pel_valid_o   = rst_ni && !fifo_empty;
  assign out_pel_data_o    = out_pel_valid_o ? fifo_mem[rd_ptr] : '0;
  assign ready_o           = !rst_ni || ((state == IDLE) && !clear_i);
  assign push              = k_out_pel_valid_i && k_out_pel_ready_o;
  assign pop               = out_pel_valid_o && out_pel_ready_i;
  // Count saturates at the limit so stray results past the job end never overrun it.
  assign count_nxt         = (pop && (count != limit)) ? count + CNT_WIDTH'(1) : count;
  assign k_size_o          = k_size;
  assign cnt_out_pel_o     = count;
  assign done_o            = done;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= k_out_pel_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state  <= IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
      count  <= '0;
      limit  <= '0;
      k_size <= '0;
      done   <= 1'b0;
    end else if (clear_i) begin
      state  <= IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      done  <= 1'b0;
      count <= count_nxt;
      occ   <= occ + OCC_WIDTH'(push) - OCC_WIDTH'(pop);
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            limit <= cnt_limit_i;
            count <= '0;
            if (cnt_limit_i != '0) state <= LOAD_SIZE;
            else                   done  <= 1'b1;
          end
        end
        LOAD_SIZE: begin
          if (in_size_valid_i && enable_i) begin
            k_size <= in_size_data_i;
            state  <= RUN;
          end
        end
        RUN: begin
          if (count_nxt == limit) state <= FLUSH;
        end
        FLUSH: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROBERTS_MDC_ENGINE_PERF_EN
  logic [31:0] busy_cycles;

  // Counts every cycle spent outside IDLE for the current job, saturating.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_cycles <= '0;
    end else if (state == IDLE) begin
      if (start_i && !clear_i) busy_cycles <= '0;
    end else if (busy_cycles != '1) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end

  assign busy_cycles_o = busy_cycles;
`endif

endmodule

// File: tb/tb_roberts_mdc_engine.sv
// Randomized bench for roberts_mdc_engine: pixel-order scoreboard, FIFO occupancy model, job timing.
module tb_roberts_mdc_engine;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        start_i = 1'b0;
  logic [10:0] cnt_limit_i = '0;
  logic        in_size_valid_i = 1'b0;
  logic [31:0] in_size_data_i = '0;
  logic        in_size_ready_o;
  logic        in_pel_valid_i = 1'b0;
  logic [31:0] in_pel_data_i = '0;
  logic        in_pel_ready_o;
  logic [31:0] k_size_o;
  logic        k_in_pel_valid_o;
  logic [31:0] k_in_pel_data_o;
  logic        k_in_pel_ready_i = 1'b0;
  logic        k_out_pel_valid_i = 1'b0;
  logic [31:0] k_out_pel_data_i = '0;
  logic        k_out_pel_ready_o;
  logic        out_pel_valid_o;
  logic [31:0] out_pel_data_o;
  logic        out_pel_ready_i = 1'b0;
  logic [10:0] cnt_out_pel_o;
  logic        done_o;
  logic        ready_o;
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
  logic [31:0] busy_cycles_o;
`endif

  int checks = 0;
  int failures = 0;

  roberts_mdc_engine dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .enable_i          (enable_i),
    .start_i           (start_i),
    .cnt_limit_i       (cnt_limit_i),
    .in_size_valid_i   (in_size_valid_i),
    .in_size_data_i    (in_size_data_i),
    .in_size_ready_o   (in_size_ready_o),
    .in_pel_valid_i    (in_pel_valid_i),
    .in_pel_data_i     (in_pel_data_i),
    .in_pel_ready_o    (in_pel_ready_o),
    .k_size_o          (k_size_o),
    .k_in_pel_valid_o  (k_in_pel_valid_o),
    .k_in_pel_data_o   (k_in_pel_data_o),
    .k_in_pel_ready_i  (k_in_pel_ready_i),
    .k_out_pel_valid_i (k_out_pel_valid_i),
    .k_out_pel_data_i  (k_out_pel_data_i),
    .k_out_pel_ready_o (k_out_pel_ready_o),
    .out_pel_valid_o   (out_pel_valid_o),
    .out_pel_data_o    (out_pel_data_o),
    .out_pel_ready_i   (out_pel_ready_i),
    .cnt_out_pel_o     (cnt_out_pel_o),
    .done_o            (done_o),
    .ready_o           (ready_o)
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
    ,
    .busy_cycles_o     (busy_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic idle_inputs();
    start_i           = 1'b0;
    clear_i           = 1'b0;
    enable_i          = 1'b1;
    in_size_valid_i   = 1'b0;
    in_pel_valid_i    = 1'b0;
    k_in_pel_ready_i  = 1'b0;
    k_out_pel_valid_i = 1'b0;
    out_pel_ready_i   = 1'b0;
  endtask

  // One job from start to done (or to a clear once clr_at beats are out); caller sits at a negedge.
  task automatic run_job(input int lim, input logic [31:0] size, input bit rnd,
                         input int st_beg, input int st_len, input int en_beg, input int en_len,
                         input int clr_at, output int max_occ);
    logic [31:0] exp_q[$];
    logic [31:0] kq[$];
    int cnt = 0, occ = 0, sent = 0, fin = -1;
    bit size_done = 0, clr_now = 0, finished = 0;
    bit sz_f, in_f, kin_f, ko_f, o_f;
    logic [31:0] kin_d, in_d;
    max_occ = 0;
    for (int e = 0; e < 3000 && !finished; e++) begin
      start_i           = (e == 0) || (rnd && $urandom_range(0, 7) == 0);
      cnt_limit_i       = (e == 0) ? 11'(lim) : 11'($urandom_range(0, 2047));
      clear_i           = clr_now;
      enable_i          = !(e >= en_beg && e < en_beg + en_len);
      in_size_valid_i   = !size_done && (!rnd || coin());
      in_size_data_i    = size_done ? $urandom : size;
      in_pel_valid_i    = (sent < lim) && (!rnd || coin());
      in_pel_data_i     = $urandom;
      k_in_pel_ready_i  = !rnd || coin();
      k_out_pel_valid_i = (kq.size() > 0) && (!rnd || coin());
      k_out_pel_data_i  = (kq.size() > 0) ? kq[0] : $urandom;
      out_pel_ready_i   = !(e >= st_beg && e < st_beg + st_len) && (!rnd || coin());
      #1;
      if (!enable_i) begin
        check("en_in_ready", 64'(in_pel_ready_o), 64'd0);
        check("en_kout_ready", 64'(k_out_pel_ready_o), 64'd0);
        check("en_size_ready", 64'(in_size_ready_o), 64'd0);
      end
      if (occ == 2) check("fifo_full_ready", 64'(k_out_pel_ready_o), 64'd0);
      check("out_valid", 64'(out_pel_valid_o), 64'(occ != 0));
      sz_f  = in_size_valid_i && in_size_ready_o;
      in_f  = in_pel_valid_i && in_pel_ready_o;
      kin_f = k_in_pel_valid_o && k_in_pel_ready_i;
      ko_f  = k_out_pel_valid_i && k_out_pel_ready_o;
      o_f   = out_pel_valid_o && out_pel_ready_i;
      check("pass_handshake", 64'(kin_f), 64'(in_f));
      if (kin_f) check("pass_data", 64'(k_in_pel_data_o), 64'(in_pel_data_i));
      if (o_f) begin
        if (exp_q.size() == 0) check("out_extra", 64'(out_pel_data_o), 64'hDEAD_0000_0000);
        else check("out_data", 64'(out_pel_data_o), 64'(exp_q[0]));
      end
      kin_d = k_in_pel_data_o;
      in_d  = in_pel_data_i;
      @(posedge clk);
      if (sz_f) size_done = 1;
      if (kin_f) kq.push_back(kin_d);
      if (in_f) begin exp_q.push_back(in_d); sent++; end
      if (ko_f) begin void'(kq.pop_front()); occ++; end
      if (o_f) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        occ--; cnt++;
        if (cnt == lim) fin = e;
      end
      if (occ > max_occ) max_occ = occ;
      @(negedge clk);
      if (clr_now) begin
        clear_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("clr_ready", 64'(ready_o), 64'd1);
        check("clr_cnt", 64'(cnt_out_pel_o), 64'd0);
        check("clr_out_valid", 64'(out_pel_valid_o), 64'd0);
        check("clr_done", 64'(done_o), 64'd0);
        check("clr_ksize", 64'(k_size_o), 64'(size));
        finished = 1;
      end else begin
        check("cnt", 64'(cnt_out_pel_o), 64'(cnt));
        check("done", 64'(done_o), 64'(fin >= 0 && e == fin + 1));
        check("ready", 64'(ready_o), 64'(fin >= 0 && e == fin + 1));
        if (size_done) check("ksize", 64'(k_size_o), 64'(size));
        if (fin >= 0 && e == fin + 1) begin
          finished = 1;
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
          check("busy", 64'(busy_cycles_o), 64'(fin + 1));
`endif
        end else if (clr_at >= 0 && cnt == clr_at) begin
          clr_now = 1;
        end
      end
    end
    if (!finished) check("job_timeout", 64'd0, 64'd1);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    check("post_done", 64'(done_o), 64'd0);
    check("post_ready", 64'(ready_o), 64'd1);
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
    if (!clr_now) check("busy_held", 64'(busy_cycles_o), 64'(fin + 1));
`endif
  endtask

  initial begin
    int mo;
    int lim;
    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_out_valid", 64'(out_pel_valid_o), 64'd0);
    check("rst_out_data", 64'(out_pel_data_o), 64'd0);
    check("rst_cnt", 64'(cnt_out_pel_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_ksize", 64'(k_size_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("idle_ready", 64'(ready_o), 64'd1);
    check("idle_size_ready", 64'(in_size_ready_o), 64'd0);

    run_job(4, 32'h0040_0030, 1'b0, -1, 0, -1, 0, -1, mo);
    run_job(3, 32'h0010_0010, 1'b0, 2, 6, -1, 0, -1, mo);
    check("fifo_fill", 64'(mo), 64'd2);
    run_job(6, 32'h0020_0018, 1'b0, -1, 0, 4, 5, -1, mo);
    run_job(8, 32'h0008_0008, 1'b0, -1, 0, -1, 0, 2, mo);
    run_job(2, 32'h0004_0004, 1'b0, -1, 0, -1, 0, -1, mo);

    // Zero-length job: done one cycle after start, no handshakes.
    start_i = 1'b1; cnt_limit_i = '0; in_size_valid_i = 1'b1; in_pel_valid_i = 1'b1; k_in_pel_ready_i = 1'b1;
    #1;
    check("z_size_ready", 64'(in_size_ready_o), 64'd0);
    check("z_pel_ready", 64'(in_pel_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    in_size_valid_i = 1'b1;
    #1;
    check("z_done", 64'(done_o), 64'd1);
    check("z_ready", 64'(ready_o), 64'd1);
    check("z_cnt", 64'(cnt_out_pel_o), 64'd0);
    check("z_size_idle", 64'(in_size_ready_o), 64'd0);
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
    check("z_busy", 64'(busy_cycles_o), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    check("z_done_low", 64'(done_o), 64'd0);

    for (int j = 0; j < 10; j++) begin
      lim = $urandom_range(1, 20);
      run_job(lim, $urandom, 1'b1, $urandom_range(0, 20), $urandom_range(0, 8),
              $urandom_range(0, 30), $urandom_range(0, 6), -1, mo);
    end
    run_job(12, $urandom, 1'b1, -1, 0, -1, 0, 5, mo);
    run_job(5, $urandom, 1'b1, 3, 4, 6, 3, -1, mo);

    // Reset in the middle of a job with results buffered.
    start_i = 1'b1; cnt_limit_i = 11'd5; in_size_valid_i = 1'b1; in_size_data_i = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    k_out_pel_valid_i = 1'b1; k_out_pel_data_i = 32'hCAFE_0001;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_valid", 64'(out_pel_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("mr_ready", 64'(ready_o), 64'd1);
    check("mr_out_valid", 64'(out_pel_valid_o), 64'd0);
    check("mr_out_data", 64'(out_pel_data_o), 64'd0);
    check("mr_kout_ready", 64'(k_out_pel_ready_o), 64'd0);
    check("mr_size_ready", 64'(in_size_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("mr_cnt", 64'(cnt_out_pel_o), 64'd0);
    check("mr_ksize", 64'(k_size_o), 64'd0);
    check("mr_done", 64'(done_o), 64'd0);
`ifdef ROBERTS_MDC_ENGINE_PERF_EN
    check("mr_busy", 64'(busy_cycles_o), 64'd0);
`endif
    rst_ni = 1'b1;
    idle_inputs();
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("mr_no_done", 64'(done_o), 64'd0);
      check("mr_empty", 64'(out_pel_valid_o), 64'd0);
    end
    run_job(3, 32'h0002_0002, 1'b0, -1, 0, -1, 0, -1, mo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
